cla_operand_joiner: RTL and testbench
=====================================

// Module: cla_operand_joiner
// PURPOSE
//  Upstream operand-pairing stage for the pipelined CLA adder. Accepts op1 and op2
//  words on two independent valid/ready streams, buffers each in its own FIFO, and
//  issues matched pairs with valid_op1 and valid_op2 asserted in the same cycle.
//  The adder only adds when both valids are high together; this block guarantees it.
//  Output side has no backpressure: the adder accepts one pair per clock.
// PARAMETERS
//  W      128  operand width; must equal the adder's w.
//  DEPTH  4    entries per FIFO; power of 2, >= 2.
//  AW     $clog2(DEPTH)  derived pointer width; do not override.
// PORTS
//  clk        in   1       rising-edge clock
//  rstn       in   1       asynchronous active-low reset
//  flush      in   1       synchronous clear of both FIFOs and the output stage
//  in1_data   in   W       operand-1 word
//  in1_valid  in   1       in1_data valid
//  in1_ready  out  1       FIFO1 can accept a word
//  in2_data   in   W       operand-2 word
//  in2_valid  in   1       in2_data valid
//  in2_ready  out  1       FIFO2 can accept a word
//  op1        out  W       paired operand 1 (to adder op1)
//  op2        out  W       paired operand 2 (to adder op2)
//  valid_op1  out  1       pair valid (to adder valid_op1)
//  valid_op2  out  1       pair valid (to adder valid_op2); always equals valid_op1
//  lvl1       out  AW+1    FIFO1 occupancy, 0..DEPTH
//  lvl2       out  AW+1    FIFO2 occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rstn=0, async): pointers, lvl1 and lvl2 clear to 0; op1 and op2 clear to 0;
//   valid_op1 and valid_op2 clear to 0. FIFO RAM contents are don't-care.
//   After reset, inN_ready=1.
//  Ready: inN_ready = (lvlN != DEPTH) & ~flush. Combinational from registered state.
//   A full FIFO does not accept a word even in a cycle where it pops.
//  Push: on the edge where inN_valid & inN_ready, write inN_data at the write
//   pointer, advance the pointer (wraps modulo DEPTH), and increment lvlN.
//  Pop: pop = (lvl1!=0) & (lvl2!=0) & ~flush. On that edge, load op1 and op2 from the
//   FIFO heads and set valid_op1=valid_op2=1. Both read pointers advance (wrap).
//  No pop: valid_op1 and valid_op2 go to 0 on the next edge. op1 and op2 hold their
//   last values.
//  Push and pop on the same edge: lvlN is unchanged (+1-1).
//  Latency: a word accepted at edge k, with its partner already buffered, appears on
//   op1/op2 with valid after edge k+1. Throughput is 1 pair per clock.
//  Order: strict FIFO per stream. The Nth op1 word is paired with the Nth op2 word.
//  Flush (sampled at edge): clear both FIFOs; valid_op1 and valid_op2 go to 0; no push
//   and no pop. Data offered during flush is not accepted, because ready=0.
//  Reset mid-operation: all buffered pairs are lost. No output glitch beyond the
//   async clear.
//  lvl outputs are registered counters, not pointer differences; no wrap ambiguity.
// TESTING
//  1 Reset: rstn=0 mid-traffic -> valid_op1=valid_op2=0, lvl1=lvl2=0,
//    in1_ready=in2_ready=1 with no clock edge required.
//  2 Simultaneous: in1=5, in2=7 offered together at edge k -> op1=5, op2=7,
//    both valids=1 for one cycle after edge k+1.
//  3 Skew: push op1 words 1,2,3 then, 4 cycles later, op2 words 10,20,30 ->
//    pairs (1,10),(2,20),(3,30) on 3 consecutive cycles; lvl1 reads 3 before
//    the first op2 word.
//  4 Full: push DEPTH=4 op1 words with no op2 -> in1_ready=0 with lvl1=4; a 5th word
//    is held off. Then push an op2 word -> one pair issues and in1_ready=1 the
//    next cycle.
//  5 Wrap and streaming: 64 back-to-back words on both streams with random idle
//    gaps -> output pairs exactly match the scoreboard order; lvl never exceeds 4.
//  6 Flush: 3 op1 and 1 op2 buffered, flush=1 for 1 cycle -> lvl1=lvl2=0, no valid
//    issued. Words offered during flush are not accepted. Later pairs are correct.

Source files
------------

// File: rtl/cla_operand_joiner_if.sv
// Operand-joiner bus: two independent valid/ready input streams, a flush
// control, and the paired-operand output that feeds the CLA adder.
//   master : upstream producer / adder side (drives inputs and flush, sees outputs)
//   slave  : the joiner itself
// Signals: flush, in1_data/in1_valid/in1_ready, in2_data/in2_valid/in2_ready,
//          op1, op2, valid_op1, valid_op2, lvl1, lvl2.
interface cla_operand_joiner_if #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          flush;
  logic [W-1:0]  in1_data;
  logic          in1_valid;
  logic          in1_ready;
  logic [W-1:0]  in2_data;
  logic          in2_valid;
  logic          in2_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic          valid_op1;
  logic          valid_op2;
  logic [AW:0]   lvl1;
  logic [AW:0]   lvl2;

  modport master (
    output flush, in1_data, in1_valid, in2_data, in2_valid,
    input  in1_ready, in2_ready, op1, op2, valid_op1, valid_op2, lvl1, lvl2
  );

  modport slave (
    input  flush, in1_data, in1_valid, in2_data, in2_valid,
    output in1_ready, in2_ready, op1, op2, valid_op1, valid_op2, lvl1, lvl2
  );
endinterface

// File: rtl/cla_operand_joiner.sv
// Operand-pairing stage ahead of the pipelined CLA adder. Each operand stream
// is buffered in its own DEPTH-entry FIFO; whenever both FIFOs hold a word the
// heads are popped together and presented on op1/op2 with both valids high
// for one cycle. The adder consumes one pair per clock, so there is no output
// backpressure.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   cla_operand_joiner_if slave modport (flush, input streams,
//         paired outputs, FIFO occupancy levels)
module cla_operand_joiner #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  cla_operand_joiner_if.slave  bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem1 [DEPTH];
  logic [W-1:0]  mem2 [DEPTH];
  logic [AW-1:0] wp1, rp1, wp2, rp2;
  logic [AW:0]   lvl1, lvl2;
  logic [W-1:0]  op1_q, op2_q;
  logic          vld_q;
  logic          ready1, ready2;
  logic          push1, push2, pop;

  // Ready looks only at the registered level, so a full FIFO stays closed
  // even in a cycle where it is also being popped.
  always_comb begin
    ready1 = (lvl1 != FULL) & ~bus.flush;
    ready2 = (lvl2 != FULL) & ~bus.flush;
    push1  = bus.in1_valid & ready1;
    push2  = bus.in2_valid & ready2;
    pop    = (lvl1 != '0) & (lvl2 != '0) & ~bus.flush;
  end

  // Storage carries no reset; contents are only read behind a nonzero level.
  always_ff @(posedge clk) begin
    if (push1) mem1[wp1] <= bus.in1_data;
    if (push2) mem2[wp2] <= bus.in2_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp1   <= '0;
      rp1   <= '0;
      wp2   <= '0;
      rp2   <= '0;
      lvl1  <= '0;
      lvl2  <= '0;
      op1_q <= '0;
      op2_q <= '0;
      vld_q <= 1'b0;
    end else if (bus.flush) begin
      // op1/op2 keep their last values; only the valid is dropped.
      wp1   <= '0;
      rp1   <= '0;
      wp2   <= '0;
      rp2   <= '0;
      lvl1  <= '0;
      lvl2  <= '0;
      vld_q <= 1'b0;
    end else begin
      if (push1) wp1 <= wp1 + AW'(1);
      if (push2) wp2 <= wp2 + AW'(1);
      if (pop) begin
        rp1   <= rp1 + AW'(1);
        rp2   <= rp2 + AW'(1);
        op1_q <= mem1[rp1];
        op2_q <= mem2[rp2];
      end
      vld_q <= pop;
      case ({push1, pop})
        2'b10:   lvl1 <= lvl1 + (AW+1)'(1);
        2'b01:   lvl1 <= lvl1 - (AW+1)'(1);
        default: ;
      endcase
      case ({push2, pop})
        2'b10:   lvl2 <= lvl2 + (AW+1)'(1);
        2'b01:   lvl2 <= lvl2 - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign bus.in1_ready = ready1;
  assign bus.in2_ready = ready2;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.valid_op1 = vld_q;
  assign bus.valid_op2 = vld_q;
  assign bus.lvl1      = lvl1;
  assign bus.lvl2      = lvl2;
endmodule

// File: tb/tb_cla_operand_joiner.sv
// Bench for cla_operand_joiner: queue-based reference model of two FIFOs that
// pair their Nth words, a scoreboard of expected pairs tagged with the cycle
// they must appear in, and a monitor that compares DUT outputs every cycle.
module tb_cla_operand_joiner;
  localparam int unsigned W     = 128;
  localparam int unsigned DEPTH = 4;

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t       a;
    word_t       b;
    int unsigned tag;
  } pair_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  cla_operand_joiner_if #(.W(W), .DEPTH(DEPTH)) bus ();

  cla_operand_joiner #(.W(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  word_t mq1[$];
  word_t mq2[$];
  word_t tx1[$];
  word_t tx2[$];
  pair_t expq[$];

  int unsigned idle1 = 0;
  int unsigned idle2 = 0;
  logic        fl    = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each falling edge, compare outputs against the scoreboard.
  always @(negedge clk) begin
    bit    ev;
    pair_t p;
    cyc++;
    if (!rstn) begin
      chk("rst_valid_op1", W'(bus.valid_op1), '0);
      chk("rst_valid_op2", W'(bus.valid_op2), '0);
      chk("rst_lvl1", W'(bus.lvl1), '0);
      chk("rst_lvl2", W'(bus.lvl2), '0);
      chk("rst_in1_ready", W'(bus.in1_ready), W'(1));
      chk("rst_in2_ready", W'(bus.in2_ready), W'(1));
    end else begin
      while (expq.size() > 0 && expq[0].tag < cyc) void'(expq.pop_front());
      ev = (expq.size() > 0) && (expq[0].tag == cyc);
      chk("valid_op1", W'(bus.valid_op1), W'(ev));
      chk("valid_op2", W'(bus.valid_op2), W'(ev));
      if (ev) begin
        p = expq.pop_front();
        chk("op1", bus.op1, p.a);
        chk("op2", bus.op2, p.b);
      end
      chk("lvl1", W'(bus.lvl1), W'(mq1.size()));
      chk("lvl2", W'(bus.lvl2), W'(mq2.size()));
      chk("lvl_bound", W'((bus.lvl1 <= DEPTH) && (bus.lvl2 <= DEPTH)), W'(1));
    end
  end

  // Reference model: evaluated just before each rising edge with inputs stable.
  always @(negedge clk) begin
    int unsigned s1, s2;
    pair_t       p;
    #4;
    if (!rstn) begin
      mq1.delete();
      mq2.delete();
      expq.delete();
    end else begin
      s1 = mq1.size();
      s2 = mq2.size();
      chk("in1_ready", W'(bus.in1_ready), W'((s1 != DEPTH) && !bus.flush));
      chk("in2_ready", W'(bus.in2_ready), W'((s2 != DEPTH) && !bus.flush));
      if (bus.flush) begin
        mq1.delete();
        mq2.delete();
      end else begin
        if (s1 > 0 && s2 > 0) begin
          p.a   = mq1.pop_front();
          p.b   = mq2.pop_front();
          p.tag = cyc + 1;
          expq.push_back(p);
        end
        if (bus.in1_valid && s1 != DEPTH) mq1.push_back(bus.in1_data);
        if (bus.in2_valid && s2 != DEPTH) mq2.push_back(bus.in2_data);
      end
    end
  end

  function automatic word_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive n cycles from the tx queues; a word leaves tx only once accepted.
  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      bus.flush     = fl;
      bus.in1_valid = (tx1.size() > 0) && ($urandom_range(99) >= idle1);
      bus.in2_valid = (tx2.size() > 0) && ($urandom_range(99) >= idle2);
      if (bus.in1_valid) bus.in1_data = tx1[0];
      else               bus.in1_data = rnd_word();
      if (bus.in2_valid) bus.in2_data = tx2[0];
      else               bus.in2_data = rnd_word();
      #1;
      if (bus.in1_valid && bus.in1_ready) void'(tx1.pop_front());
      if (bus.in2_valid && bus.in2_ready) void'(tx2.pop_front());
    end
  endtask

  task automatic drain(input int unsigned max_cycles);
    int unsigned n = 0;
    while ((tx1.size() > 0 || tx2.size() > 0) && n < max_cycles) begin
      run(1);
      n++;
    end
    chk("drain_timeout", W'(tx1.size() + tx2.size()), '0);
    run(6);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_valid_op1", W'(bus.valid_op1), '0);
    chk("async_valid_op2", W'(bus.valid_op2), '0);
    chk("async_lvl1", W'(bus.lvl1), '0);
    chk("async_lvl2", W'(bus.lvl2), '0);
    chk("async_in1_ready", W'(bus.in1_ready), W'(1));
    chk("async_in2_ready", W'(bus.in2_ready), W'(1));
    tx1.delete();
    tx2.delete();
    bus.in1_valid = 1'b0;
    bus.in2_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in2_valid = 1'b0;
    bus.in1_data  = '0;
    bus.in2_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;

    // Simultaneous pair.
    tx1.push_back(W'(5));
    tx2.push_back(W'(7));
    run(4);

    // Skewed streams.
    tx1.push_back(W'(1)); tx1.push_back(W'(2)); tx1.push_back(W'(3));
    run(7);
    chk("skew_lvl1", W'(bus.lvl1), W'(3));
    tx2.push_back(W'(10)); tx2.push_back(W'(20)); tx2.push_back(W'(30));
    run(6);

    // Full FIFO1, fifth word held off until a pair issues.
    for (int unsigned i = 0; i < 5; i++) tx1.push_back(W'(100 + i));
    run(8);
    chk("full_lvl1", W'(bus.lvl1), W'(4));
    chk("full_in1_ready", W'(bus.in1_ready), '0);
    chk("full_held", W'(tx1.size()), W'(1));
    tx2.push_back(W'(200));
    run(3);
    for (int unsigned i = 1; i < 5; i++) tx2.push_back(W'(200 + i));
    run(8);

    // Flush with 3 op1 and 1 op2 buffered; words offered during flush wait.
    tx1.push_back(W'(16'h61)); tx1.push_back(W'(16'h62)); tx1.push_back(W'(16'h63));
    run(5);
    tx2.push_back(W'(16'h71));
    run(1);
    fl = 1'b1;
    tx1.push_back(W'(16'h64));
    tx2.push_back(W'(16'h72));
    run(1);
    fl = 1'b0;
    chk("flush_rejects_in1", W'(tx1.size()), W'(1));
    chk("flush_rejects_in2", W'(tx2.size()), W'(1));
    run(6);

    // Random streaming with idle gaps, exercising pointer wrap.
    idle1 = 30;
    idle2 = 30;
    for (int unsigned i = 0; i < 64; i++) begin
      tx1.push_back(rnd_word());
      tx2.push_back(rnd_word());
    end
    drain(2000);
    idle1 = 0;
    idle2 = 0;

    // Reset in the middle of traffic, then normal operation resumes.
    for (int unsigned i = 0; i < 4; i++) begin
      tx1.push_back(rnd_word());
      tx2.push_back(rnd_word());
    end
    run(3);
    mid_reset();
    tx1.push_back(W'(9));
    tx2.push_back(W'(11));
    run(5);

    chk("scoreboard_empty", W'(expq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
